// File: rtl/four_bank_mem.sv
// four_bank_mem
// Banked main-memory model for the cache controller's memory side.
// One word request per cycle is steered to one of four interleaved banks
// by addr[2:1]. Reads return after exactly two cycles; each bank stays busy
// for three cycles after it accepts a request, so a four-word line can be
// streamed across the four banks on back-to-back cycles.
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   addr      byte address (addr[2:1] = bank, addr[DEPTH_BITS+2:3] = row, addr[0] must be 0)
//   data_in   write data
//   wr, rd    write / read request (exactly one may be high)
//   data_out  read data in its return cycle, otherwise 16'h0000
//   busy      per-bank busy flags (registered)
//   stall     combinational: a legal request targets a busy bank
//   err       registered: the previous cycle carried an illegal request
module four_bank_mem #(
    parameter int DEPTH_BITS = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic [3:0]  busy,
    output logic        stall,
    output logic        err
);

    logic                  req;
    logic                  illegal;
    logic                  legal_req;
    logic                  accept;
    logic [1:0]            bank;
    logic [DEPTH_BITS-1:0] row;

    logic [15:0]           bank_q [4];

    logic                  ret_valid_reg;
    logic [1:0]            ret_bank_reg;
    logic [15:0]           data_out_reg;
    logic                  err_reg;

    assign req       = rd | wr;
    assign bank      = addr[2:1];
    assign row       = addr[DEPTH_BITS+2:3];
    // Illegality is decided before busy: an illegal request never stalls.
    assign illegal   = req & ((rd & wr) | addr[0]);
    assign legal_req = req & ~illegal;
    assign stall     = legal_req & busy[bank];
    assign accept    = legal_req & ~busy[bank] & ~rst;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [15:0] mem [0:(1<<DEPTH_BITS)-1];
            logic [15:0] q_reg;
            logic [1:0]  cnt_reg;
            logic        hit;

            assign hit = accept & (bank == 2'(gi));

            // Array is intentionally left out of reset so it maps to block RAM.
            always_ff @(posedge clk) begin
                if (hit && wr) begin
                    mem[row] <= data_in;
                end
                if (hit && rd) begin
                    q_reg <= mem[row];
                end
            end

            // Loaded with 3 on accept: busy during the three following cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 2'd0;
                end else if (hit) begin
                    cnt_reg <= 2'd3;
                end else if (cnt_reg != 2'd0) begin
                    cnt_reg <= cnt_reg - 2'd1;
                end
            end

            assign busy[gi]   = (cnt_reg != 2'd0);
            assign bank_q[gi] = q_reg;
        end
    endgenerate

    // Return pipe: stage 1 is the bank's registered read, stage 2 selects
    // the bank and zeroes the bus when nothing is returning.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid_reg <= 1'b0;
            ret_bank_reg  <= 2'd0;
            data_out_reg  <= 16'h0000;
            err_reg       <= 1'b0;
        end else begin
            ret_valid_reg <= accept & rd;
            ret_bank_reg  <= bank;
            data_out_reg  <= ret_valid_reg ? bank_q[ret_bank_reg] : 16'h0000;
            err_reg       <= illegal;
        end
    end

    // A reset cycle flushes data already scheduled for that same cycle.
    assign data_out = rst ? 16'h0000 : data_out_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_four_bank_mem.sv
// tb_four_bank_mem
// Randomized plus directed stimulus against a cycle-indexed reference model:
// the model tracks memory as words, bank occupancy as "cycle of last accept",
// and read returns as a queue of (due cycle, data) entries. A monitor on the
// falling edge pops the queue and compares data_out, busy, err and stall.
module tb_four_bank_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic [3:0]  busy;
    logic        stall;
    logic        err;

    always #5 clk = ~clk;

    four_bank_mem #(.DEPTH_BITS(13)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .busy     (busy),
        .stall    (stall),
        .err      (err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    logic [15:0] ref_mem [int];
    int          last_acc [4];
    ret_t        sb_q [$];
    bit          prev_rst     = 1'b1;
    bit          prev_illegal = 1'b0;
    bit          exp_err      = 1'b0;
    bit          exp_stall    = 1'b0;
    logic [3:0]  exp_busy     = 4'b0000;

    // One cycle of stimulus; also advances the model for that cycle.
    task automatic step(input bit r, input bit rdi, input bit wri,
                        input logic [15:0] a, input logic [15:0] d,
                        output bit acc, output bit seen_stall);
        bit   req_b;
        bit   ill_b;
        int   b;
        int   word;
        ret_t keep [$];
        @(posedge clk);
        #1;
        cyc++;
        if (prev_rst) begin
            for (int k = 0; k < 4; k++) last_acc[k] = -100;
        end
        exp_err = prev_illegal;
        for (int k = 0; k < 4; k++)
            exp_busy[k] = ((cyc - last_acc[k]) >= 1) && ((cyc - last_acc[k]) <= 3);
        rst = r; rd = rdi; wr = wri; addr = a; data_in = d;
        req_b     = rdi | wri;
        ill_b     = req_b && ((rdi && wri) || a[0]);
        b         = int'(a[2:1]);
        exp_stall = req_b && !ill_b && exp_busy[b];
        acc       = req_b && !ill_b && !exp_busy[b] && !r;
        if (acc) begin
            last_acc[b] = cyc;
            word = int'(a[15:1]);
            if (wri) ref_mem[word] = d;
            else begin
                ret_t e;
                e.due  = cyc + 2;
                e.data = ref_mem.exists(word) ? ref_mem[word] : 16'hxxxx;
                sb_q.push_back(e);
            end
        end
        if (r) begin
            foreach (sb_q[i]) if (sb_q[i].due < cyc) keep.push_back(sb_q[i]);
            sb_q = keep;
        end
        prev_illegal = ill_b && !r;
        prev_rst     = r;
        #1;
        seen_stall = stall;
    endtask

    task automatic idle(input int n);
        bit a_, s_;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, a_, s_);
    endtask

    task automatic op(input bit rdi, input bit wri, input logic [15:0] a, input logic [15:0] d);
        bit a_, s_;
        step(1'b0, rdi, wri, a, d, a_, s_);
    endtask

    // Hold a request until the model accepts it; returns observed DUT stall cycles.
    task automatic issue(input bit rdi, input bit wri, input logic [15:0] a,
                         input logic [15:0] d, output int stalls);
        bit acc, s;
        int tries = 0;
        stalls = 0;
        acc = 1'b0;
        while (!acc && tries < 8) begin
            step(1'b0, rdi, wri, a, d, acc, s);
            if (s) stalls++;
            tries++;
        end
        if (!acc) begin
            checks++; failures++;
            $display("FAIL issue_timeout addr=%h not accepted within 8 cycles", a);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (cyc > 0) begin
            logic [15:0] exp_data;
            exp_data = 16'h0000;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                exp_data = sb_q[0].data;
                void'(sb_q.pop_front());
                $display("cyc=%0d read return data_out=%h expected=%h", cyc, data_out, exp_data);
            end
            checks++;
            if (data_out !== exp_data) begin
                failures++;
                $display("FAIL data_out cyc=%0d got=%h want=%h", cyc, data_out, exp_data);
            end
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
            end
            checks++;
            if (err !== exp_err) begin
                failures++;
                $display("FAIL err cyc=%0d got=%b want=%b", cyc, err, exp_err);
            end
            checks++;
            if (stall !== exp_stall) begin
                failures++;
                $display("FAIL stall cyc=%0d got=%b want=%b", cyc, stall, exp_stall);
            end
        end
    end

    initial begin
        bit a_, s_;
        int st;
        rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;

        // Reset held two cycles with a read presented
        step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, a_, s_);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, a_, s_);
        idle(2);

        // Line fill writes, plus a bank-0 word used by the conflict test
        op(1'b0, 1'b1, 16'h0040, 16'h1111);
        op(1'b0, 1'b1, 16'h0042, 16'h2222);
        op(1'b0, 1'b1, 16'h0044, 16'h3333);
        op(1'b0, 1'b1, 16'h0046, 16'h4444);
        idle(4);
        op(1'b0, 1'b1, 16'h0048, 16'h5555);
        idle(4);
        // Line read on back-to-back cycles
        op(1'b1, 1'b0, 16'h0040, 16'h0000);
        op(1'b1, 1'b0, 16'h0042, 16'h0000);
        op(1'b1, 1'b0, 16'h0044, 16'h0000);
        op(1'b1, 1'b0, 16'h0046, 16'h0000);
        idle(5);

        // Bank conflict: second bank-0 read stalls three cycles
        op(1'b1, 1'b0, 16'h0040, 16'h0000);
        issue(1'b1, 1'b0, 16'h0048, 16'h0000, st);
        checks++;
        if (st != 3) begin
            failures++;
            $display("FAIL conflict_stall_cycles got=%0d want=3", st);
        end
        idle(5);

        // Illegal requests
        op(1'b1, 1'b1, 16'h0010, 16'h0000);
        idle(1);
        op(1'b1, 1'b0, 16'h0011, 16'h0000);
        idle(4);

        // Reset mid-fill
        op(1'b1, 1'b0, 16'h0040, 16'h0000);
        op(1'b1, 1'b0, 16'h0042, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, a_, s_);
        idle(2);
        op(1'b1, 1'b0, 16'h0040, 16'h0000);
        idle(4);

        // Write then read same word
        op(1'b0, 1'b1, 16'h0100, 16'hBEEF);
        idle(3);
        op(1'b1, 1'b0, 16'h0100, 16'h0000);
        idle(4);

        // Initialise a 64-word window, then randomize inside it
        for (int w = 0; w < 64; w++)
            issue(1'b0, 1'b1, 16'(w << 1), 16'($urandom), st);
        idle(4);
        for (int i = 0; i < 800; i++) begin
            int          sel;
            logic [15:0] ra;
            logic [15:0] rdat;
            bit          rr;
            sel  = int'($urandom_range(0, 9));
            ra   = 16'($urandom_range(0, 63) << 1);
            rdat = 16'($urandom);
            rr   = ($urandom_range(0, 49) == 0);
            case (sel)
                0:       step(rr, 1'b0, 1'b0, ra, rdat, a_, s_);
                1:       step(rr, 1'b1, 1'b1, ra, rdat, a_, s_);
                2:       step(rr, 1'b1, 1'b0, ra | 16'h0001, rdat, a_, s_);
                3, 4, 5, 6: step(rr, 1'b1, 1'b0, ra, rdat, a_, s_);
                default: step(rr, 1'b0, 1'b1, ra, rdat, a_, s_);
            endcase
        end
        idle(6);
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
